// File: rtl/draw_axi_slave_ram.sv
// AXI4 slave RAM (32-bit words, INCR bursts) with independent read and write engines.
// Latency: first RDATA 2 cycles after the AR handshake, then one beat per 2 cycles minimum; BVALID 1 cycle after the last W beat.
// Backpressure: one burst per direction; AWREADY/ARREADY low while busy; R and B outputs hold until RREADY/BREADY.
// Optional error responses for out-of-range start addresses: define DRAW_AXI_SLAVE_RAM_ERRRESP_EN.
module draw_axi_slave_ram #(
  parameter int C_S_AXI_ID_WIDTH = 1,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [31:0]                 S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [31:0]                 S_AXI_WDATA,
  input  logic [3:0]                  S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [31:0]                 S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_RID,
  output logic [31:0]                 S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);

  localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;

  typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Storage is deliberately not reset; it keeps its contents across ARESETN.
  logic [31:0] mem [DEPTH];

  w_state_t                    w_state, w_next;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id;
  idx_t                        w_idx;
  logic [7:0]                  w_cnt;
  logic                        w_err;

  r_state_t                    r_state, r_next;
  logic [C_S_AXI_ID_WIDTH-1:0] r_id;
  idx_t                        r_idx;
  logic [7:0]                  r_cnt;
  logic                        r_err;
  logic [31:0]                 r_data;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_err_in, ar_err_in;
  logic unused_addr;

`ifdef DRAW_AXI_SLAVE_RAM_ERRRESP_EN
  // Any start address bit above the RAM window flags the whole burst as an error.
  assign aw_err_in   = |S_AXI_AWADDR[31:C_MEM_DEPTH_LOG2+2];
  assign ar_err_in   = |S_AXI_ARADDR[31:C_MEM_DEPTH_LOG2+2];
  assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  // Upper address bits alias onto the RAM window; responses are always OKAY.
  assign aw_err_in   = 1'b0;
  assign ar_err_in   = 1'b0;
  assign unused_addr = ^{S_AXI_AWADDR[31:C_MEM_DEPTH_LOG2+2], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:C_MEM_DEPTH_LOG2+2], S_AXI_ARADDR[1:0]};
`endif

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = w_err ? 2'b10 : 2'b00;
  assign S_AXI_RID   = r_id;
  assign S_AXI_RDATA = r_data;
  assign S_AXI_RRESP = r_err ? 2'b10 : 2'b00;

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && (w_cnt == 8'd0)) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst context: captured on AW, advanced once per accepted W beat.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_id  <= '0;
      w_idx <= '0;
      w_cnt <= 8'd0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id  <= S_AXI_AWID;
      w_idx <= S_AXI_AWADDR[C_MEM_DEPTH_LOG2+1:2];
      w_cnt <= S_AXI_AWLEN;
      w_err <= aw_err_in;
    end else if (w_hs) begin
      w_idx <= w_idx + idx_t'(1);
      w_cnt <= w_cnt - 8'd1;
    end
  end

  // Byte-masked RAM write; error bursts are accepted but dropped.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = (r_cnt == 8'd0);
        if (S_AXI_RREADY) r_next = (r_cnt == 8'd0) ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst context and output data register; the fetch samples the RAM
  // before any same-edge write lands, so a colliding read sees the old word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_cnt  <= 8'd0;
      r_err  <= 1'b0;
      r_data <= 32'd0;
    end else begin
      if (ar_hs) begin
        r_id  <= S_AXI_ARID;
        r_idx <= S_AXI_ARADDR[C_MEM_DEPTH_LOG2+1:2];
        r_cnt <= S_AXI_ARLEN;
        r_err <= ar_err_in;
      end
      if (r_state == R_FETCH) begin
        r_data <= r_err ? 32'd0 : mem[r_idx];
        r_idx  <= r_idx + idx_t'(1);
      end
      if (r_hs) r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_draw_axi_slave_ram.sv
module tb_draw_axi_slave_ram;

  logic        aclk, aresetn;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int nchk = 0;
  int nerr = 0;

  // Reference model: a plain word array, 1024 words of 4 bytes.
  logic [31:0] ref_mem [1024];
  logic [31:0] wq_data [256];
  logic [3:0]  wq_strb [256];

  draw_axi_slave_ram dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef DRAW_AXI_SLAVE_RAM_ERRRESP_EN
    return a >= 32'd4096;
`else
    return (a != a);
`endif
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic id, input bit gaps);
    int   t;
    int   idx;
    bit   err;
    err = addr_err(addr);
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge aclk); t++; end
    chk("aw_ready", 32'(awready), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    chk("aw_busy", 32'(awready), 32'd0);
    idx = (addr / 4) % 1024;
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge aclk);
      end
      wvalid = 1'b1; wdata = wq_data[b]; wstrb = wq_strb[b];
      t = 0;
      while (!wready && t < 200) begin @(negedge aclk); t++; end
      chk("w_ready", 32'(wready), 32'd1);
      @(posedge aclk);
      if (!err) begin
        for (int k = 0; k < 4; k++)
          if (wq_strb[b][k]) ref_mem[idx][8*k +: 8] = wq_data[b][8*k +: 8];
      end
      idx = (idx + 1) % 1024;
      @(negedge aclk);
    end
    wvalid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 200) begin @(negedge aclk); t++; end
    chk("b_valid", 32'(bvalid), 32'd1);
    chk("b_resp", 32'(bresp), err ? 32'd2 : 32'd0);
    chk("b_id", 32'(bid), 32'(id));
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    chk("b_once", 32'(bvalid), 32'd0);
  endtask

  // mode 0: RREADY always high, 1: toggles every cycle starting low, 2: random
  task automatic axi_read(input logic [31:0] addr, input int len, input logic id, input int mode);
    logic [31:0] exp_d [256];
    bit          err, held, tog;
    int          idx, b, t;
    logic [31:0] hd;
    logic        hl;
    err = addr_err(addr);
    @(negedge aclk);
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge aclk); t++; end
    chk("ar_ready", 32'(arready), 32'd1);
    @(posedge aclk);
    idx = (addr / 4) % 1024;
    for (int k = 0; k <= len; k++) begin
      exp_d[k] = err ? 32'd0 : ref_mem[idx];
      idx = (idx + 1) % 1024;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    chk("r_fetch_lat", 32'(rvalid), 32'd0);
    chk("ar_busy", 32'(arready), 32'd0);
    @(negedge aclk);
    chk("r_first_lat", 32'(rvalid), 32'd1);
    b = 0; t = 0; held = 1'b0; tog = 1'b0; hd = '0; hl = 1'b0;
    while (b <= len && t < 3000) begin
      case (mode)
        0: rready = 1'b1;
        1: begin rready = tog; tog = !tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (held) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, hd);
        chk("r_hold_last", 32'(rlast), 32'(hl));
      end
      if (rvalid) begin
        if (rready) begin
          chk("r_data", rdata, exp_d[b]);
          chk("r_last", 32'(rlast), 32'(b == len));
          chk("r_id", 32'(rid), 32'(id));
          chk("r_resp", 32'(rresp), err ? 32'd2 : 32'd0);
          b++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end else begin
        held = 1'b0;
      end
      @(negedge aclk);
      t++;
    end
    rready = 1'b0;
    chk("r_beats", 32'(b), 32'(len + 1));
    chk("r_idle", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int t, len;
    logic [31:0] a;

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    #3;
    chk("rst_in_rvalid", 32'(rvalid), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // Fill the whole RAM with random words so every later read is defined.
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin wq_data[b] = $urandom; wq_strb[b] = 4'hF; end
      axi_write(32'(blk * 1024), 255, 1'b0, 1'b0);
    end

    // Basic 4-beat burst.
    wq_data[0] = 32'h11111111; wq_data[1] = 32'h22222222;
    wq_data[2] = 32'h33333333; wq_data[3] = 32'h44444444;
    for (int b = 0; b < 4; b++) wq_strb[b] = 4'hF;
    axi_write(32'h100, 3, 1'b1, 1'b0);
    axi_read(32'h100, 3, 1'b1, 0);

    // Byte strobe merge.
    wq_data[0] = 32'hAABBCCDD; wq_strb[0] = 4'hF;
    axi_write(32'h0, 0, 1'b0, 1'b0);
    wq_data[0] = 32'h00000011; wq_strb[0] = 4'h1;
    axi_write(32'h0, 0, 1'b1, 1'b0);
    axi_read(32'h0, 0, 1'b0, 0);

    // Burst wrapping past the top of the RAM.
    wq_data[0] = 32'h5A5A0001; wq_data[1] = 32'h5A5A0002;
    wq_strb[0] = 4'hF; wq_strb[1] = 4'hF;
    axi_write(32'hFFC, 1, 1'b0, 1'b0);
    axi_read(32'h000, 0, 1'b0, 0);
    axi_read(32'hFFC, 1, 1'b1, 2);

    // RREADY toggling every cycle.
    axi_read(32'h240, 7, 1'b1, 1);

    // Random bursts with random strobes, gaps and RREADY.
    for (int n = 0; n < 8; n++) begin
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      len = $urandom_range(0, 15);
      for (int b = 0; b <= len; b++) begin wq_data[b] = $urandom; wq_strb[b] = 4'($urandom); end
      axi_write(a, len, 1'($urandom), 1'b1);
      axi_read(a, $urandom_range(0, 15), 1'($urandom), 2);
    end

    // Same-word read and write in the same cycle: the read sees the old word.
    wq_data[0] = 32'h0BADF00D; wq_strb[0] = 4'hF;
    fork
      axi_write(32'h300, 0, 1'b0, 1'b0);
      axi_read(32'h300, 0, 1'b1, 0);
    join
    axi_read(32'h300, 0, 1'b0, 0);

    // Out-of-window write: error response or aliasing onto word 0.
    wq_data[0] = 32'hCAFEF00D; wq_strb[0] = 4'hF;
    axi_write(32'h0, 0, 1'b0, 1'b0);
    wq_data[0] = 32'h12345678; wq_strb[0] = 4'hF;
    axi_write(32'h1000, 0, 1'b1, 1'b0);
    axi_read(32'h0, 0, 1'b0, 0);
    axi_read(32'h1000, 1, 1'b1, 0);

    // Reset asserted while beat 2 of an 8-beat read is presented.
    @(negedge aclk);
    arid = 1'b1; araddr = 32'h200; arlen = 8'd7; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge aclk); t++; end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    t = 0;
    while (!rvalid && t < 200) begin @(negedge aclk); t++; end
    chk("rst_mid_beat1", 32'(rvalid), 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
    t = 0;
    while (!rvalid && t < 200) begin @(negedge aclk); t++; end
    chk("rst_mid_beat2", 32'(rvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_rlast", 32'(rlast), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_rid", 32'(rid), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rst_rel_arready", 32'(arready), 32'd1);
    chk("rst_rel_awready", 32'(awready), 32'd1);
    chk("rst_rel_rvalid", 32'(rvalid), 32'd0);
    axi_read(32'h200, 7, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
